// File: rtl/dota_pkg.sv
// Shared types and constants for the OTA scheduler.
package dota_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int MIN_SETTLE  = 2;
  localparam int SYNC_STAGES = 2;
  localparam int MAJ_SAMPLES = 3;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/dota_rr_arb.sv
// Combinational round-robin pick: lowest requesting index at or above ptr, wrapping.
module dota_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             vld,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  id
);

  int idx;

  always_comb begin
    vld = 1'b0;
    gnt = '0;
    id  = '0;
    idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!vld && req[idx]) begin
        vld      = 1'b1;
        gnt[idx] = 1'b1;
        id       = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/dota_sched.sv
// Round-robin scheduler sharing one comparator OTA between N_REQ requesters.
// Build with DOTA_SCHED_MAJORITY_EN to take a 3-sample majority vote instead of a single sample.
module dota_sched
  import dota_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int SETTLE_W = 8,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                ota_out,
  output logic                ota_en,
  output logic [ID_W-1:0]     ota_sel,
  output logic [N_REQ-1:0]    gnt,
  output logic                busy,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic                rsp_bit
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      sel_q, sel_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [SETTLE_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic                 ota_en_q, ota_en_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_bit_q, rsp_bit_d;
  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic                 sync_q;
  logic                 last_sample;
  logic [SETTLE_W-1:0]  settle_load;
  logic [ID_W-1:0]      ptr_next;

  logic                 arb_vld;
  logic [N_REQ-1:0]     arb_gnt;
  logic [ID_W-1:0]      arb_id;

  dota_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .vld (arb_vld),
    .gnt (arb_gnt),
    .id  (arb_id)
  );

  assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], ota_out};
  assign sync_q       = sync_chain_q[SYNC_STAGES-1];

  // Floor of MIN_SETTLE guarantees sync_q reflects the newly enabled OTA.
  assign settle_load = (settle_cycles < SETTLE_W'(MIN_SETTLE)) ? SETTLE_W'(MIN_SETTLE)
                                                              : settle_cycles;
  assign ptr_next    = (arb_id == ID_W'(N_REQ - 1)) ? '0 : arb_id + ID_W'(1);

`ifdef DOTA_SCHED_MAJORITY_EN
  logic [MAJ_SAMPLES-1:0] samp_q, samp_d;
  logic [1:0]             scnt_q, scnt_d;
  assign last_sample = (scnt_q == 2'(MAJ_SAMPLES - 1));
`else
  assign last_sample = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      sel_q        <= '0;
      rsp_id_q     <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      ota_en_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_bit_q    <= 1'b0;
      sync_chain_q <= '0;
`ifdef DOTA_SCHED_MAJORITY_EN
      samp_q       <= '0;
      scnt_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      rsp_id_q     <= rsp_id_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      ota_en_q     <= ota_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_bit_q    <= rsp_bit_d;
      sync_chain_q <= sync_chain_d;
`ifdef DOTA_SCHED_MAJORITY_EN
      samp_q       <= samp_d;
      scnt_q       <= scnt_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_vld) state_d = SETTLE;
      SETTLE:  if (cnt_q <= SETTLE_W'(1)) state_d = SAMPLE;
      SAMPLE:  if (last_sample) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output register updates.
  always_comb begin
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    rsp_id_d    = rsp_id_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    ota_en_d    = ota_en_q;
    rsp_valid_d = 1'b0;
    rsp_bit_d   = rsp_bit_q;
`ifdef DOTA_SCHED_MAJORITY_EN
    samp_d      = samp_q;
    scnt_d      = scnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_d    = arb_gnt;
          sel_d    = arb_id;
          ota_en_d = 1'b1;
          cnt_d    = settle_load;
          ptr_d    = ptr_next;
        end
      end
      SETTLE: cnt_d = cnt_q - SETTLE_W'(1);
      SAMPLE: begin
`ifdef DOTA_SCHED_MAJORITY_EN
        samp_d = {samp_q[MAJ_SAMPLES-2:0], sync_q};
        scnt_d = scnt_q + 2'd1;
        if (last_sample) begin
          rsp_bit_d = maj3(samp_d);
          scnt_d    = '0;
        end
`else
        rsp_bit_d = sync_q;
`endif
        if (last_sample) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = sel_q;
        end
      end
      DONE: begin
        gnt_d    = '0;
        ota_en_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign ota_en    = ota_en_q;
  assign ota_sel   = sel_q;
  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_bit   = rsp_bit_q;

endmodule

// File: tb/tb_dota_sched.sv
// Directed bench for dota_sched: latency, round-robin order, settle bounds, sampling window, reset abort.
module tb_dota_sched;

`ifdef DOTA_SCHED_MAJORITY_EN
  localparam int  EXTRA   = 2;
  localparam logic MAJ_BUILD = 1'b1;
`else
  localparam int  EXTRA   = 0;
  localparam logic MAJ_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] settle_cycles = 8'd0;
  logic       ota_out = 1'b0;
  logic       ota_en;
  logic [1:0] ota_sel;
  logic [3:0] gnt;
  logic       busy;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic       rsp_bit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dota_sched #(.N_REQ(4), .SETTLE_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .settle_cycles (settle_cycles),
    .ota_out       (ota_out),
    .ota_en        (ota_en),
    .ota_sel       (ota_sel),
    .gnt           (gnt),
    .busy          (busy),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_bit       (rsp_bit)
  );

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; settle_cycles = 8'd0; ota_out = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ota_en !== 1'b0) begin bad++; $display("FAIL reset_ota_en got=%b want=0", ota_en); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
    total++; if (rsp_bit !== 1'b0) begin bad++; $display("FAIL reset_rsp_bit got=%b want=0", rsp_bit); end
    total++; if (ota_sel !== 2'd0) begin bad++; $display("FAIL reset_ota_sel got=%0d want=0", ota_sel); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_req_busy got=%b want=0", busy); end
  endtask

  // One operation: req/settle applied in cycle T (k=0); k counts negedges after that.
  task automatic run_op(input string nm, input logic [3:0] r, input logic [7:0] sc,
                        input int exp_id, input int exp_l, input logic exp_bit,
                        input int drop_k, input int ota_k0, input logic [2:0] pat,
                        input logic base);
    logic [3:0] eg;
    int en_cnt, rsp_k, exp_k;
    logic got;
    eg = 4'b0001 << exp_id;
    exp_k = exp_l + 2 + EXTRA;
    en_cnt = 0; rsp_k = 0; got = 1'b0;
    ota_out = base; req = r; settle_cycles = sc;
    for (int k = 1; k <= exp_l + 12 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++; if (ota_sel !== 2'(exp_id)) begin bad++; $display("FAIL %s ota_sel got=%0d want=%0d", nm, ota_sel, exp_id); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy got=%b want=1", nm, busy); end
      end
      if (ota_en) begin
        en_cnt++;
        total++; if (gnt !== eg) begin bad++; $display("FAIL %s gnt k=%0d got=%b want=%b", nm, k, gnt, eg); end
      end
      if (rsp_valid) begin
        got = 1'b1; rsp_k = k; req = 4'b0000;
        total++; if (rsp_k !== exp_k) begin bad++; $display("FAIL %s latency got=%0d want=%0d", nm, rsp_k, exp_k); end
        total++; if (rsp_id !== 2'(exp_id)) begin bad++; $display("FAIL %s rsp_id got=%0d want=%0d", nm, rsp_id, exp_id); end
        total++; if (rsp_bit !== exp_bit) begin bad++; $display("FAIL %s rsp_bit got=%b want=%b", nm, rsp_bit, exp_bit); end
        total++; if (en_cnt !== exp_k) begin bad++; $display("FAIL %s ota_en_cycles got=%0d want=%0d", nm, en_cnt, exp_k); end
      end
      if (drop_k > 0 && k == drop_k) begin req = 4'b0000; settle_cycles = 8'd50; end
      if (ota_k0 >= 0 && k >= ota_k0 && k < ota_k0 + 3) ota_out = pat[k - ota_k0];
      else if (ota_k0 >= 0 && k == ota_k0 + 3) ota_out = base;
    end
    total++; if (!got) begin bad++; $display("FAIL %s timeout got=no_rsp want=rsp_at_%0d", nm, exp_k); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL %s rsp_valid_width got=%b want=0", nm, rsp_valid); end
    total++; if (busy !== 1'b0 || ota_en !== 1'b0 || gnt !== 4'b0000) begin
      bad++; $display("FAIL %s release got=busy%b/en%b/gnt%b want=0/0/0000", nm, busy, ota_en, gnt);
    end
    total++; if (rsp_id !== 2'(exp_id) || rsp_bit !== exp_bit) begin
      bad++; $display("FAIL %s hold got=id%0d/bit%b want=id%0d/bit%b", nm, rsp_id, rsp_bit, exp_id, exp_bit);
    end
  endtask

  task automatic test_single();
    run_op("single", 4'b0001, 8'd5, 0, 5, 1'b1, 0, -1, 3'b000, 1'b1);
  endtask

  task automatic test_settle_bounds();
    run_op("settle0", 4'b0100, 8'd0, 2, 2, 1'b0, 0, -1, 3'b000, 1'b0);
    run_op("settle1_wrap", 4'b1001, 8'd1, 3, 2, 1'b1, 0, -1, 3'b000, 1'b1);
  endtask

  task automatic test_drop_req();
    run_op("drop_req", 4'b0010, 8'd4, 1, 4, 1'b1, 1, -1, 3'b000, 1'b1);
  endtask

  task automatic test_settle_max();
    run_op("settle_max", 4'b0100, 8'd255, 2, 255, 1'b0, 0, -1, 3'b000, 1'b0);
  endtask

  // Sync_q in cycle T+c reflects ota_out driven at k=c-2, so k0=L-1 lines up with the sample window.
  task automatic test_sample_window();
    run_op("win_101", 4'b1111, 8'd6, 3, 6, 1'b1, 0, 5, 3'b101, 1'b0);
    run_op("win_011", 4'b0001, 8'd6, 0, 6, MAJ_BUILD ? 1'b1 : 1'b0, 0, 5, 3'b110, 1'b0);
    run_op("win_100", 4'b0010, 8'd6, 1, 6, MAJ_BUILD ? 1'b0 : 1'b1, 0, 5, 3'b001, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic seen;
    req = 4'b0100; settle_cycles = 8'd10; ota_out = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ota_en !== 1'b1) begin bad++; $display("FAIL mid_pre_en got=%b want=1", ota_en); end
    rst = 1'b1;
    #1;
    total++; if (ota_en !== 1'b0) begin bad++; $display("FAIL mid_rst_ota_en got=%b want=0", ota_en); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL mid_rst_gnt got=%b want=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_no_rsp got=%b want=0", seen); end
    run_op("after_rst", 4'b1010, 8'd2, 1, 2, 1'b1, 0, -1, 3'b000, 1'b1);
  endtask

  task automatic test_back_to_back();
    int n, exp_k;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ota_out = 1'b1; req = 4'b1111; settle_cycles = 8'd3;
    n = 0;
    for (int k = 1; k <= 60 && n < 5; k++) begin
      @(negedge clk);
      total++; if (!$onehot0(gnt)) begin bad++; $display("FAIL b2b_onehot k=%0d got=%b want=onehot0", k, gnt); end
      if (rsp_valid) begin
        exp_k = 5 + EXTRA + n * (6 + EXTRA);
        total++; if (k !== exp_k) begin bad++; $display("FAIL b2b_time n=%0d got=%0d want=%0d", n, k, exp_k); end
        total++; if (rsp_id !== 2'(n % 4)) begin bad++; $display("FAIL b2b_id n=%0d got=%0d want=%0d", n, rsp_id, n % 4); end
        n++;
        if (n == 5) req = 4'b0000;
      end
    end
    req = 4'b0000;
    total++; if (n !== 5) begin bad++; $display("FAIL b2b_count got=%0d want=5", n); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_settle_bounds();
    test_drop_req();
    test_settle_max();
    test_sample_window();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dota_sched.md
Name: dota_sched

Overview:
- Round-robin scheduler that shares the digital comparator-based OTA between N_REQ requesters.
- Per granted request: enable the OTA, route that requester's input pair onto Vip/Vin via `ota_sel`, wait a programmable settle time, sample the synchronised OTA output, and return one result bit tagged with the requester id.
- Sits between the digital control logic (`ui_in`/`uio` side) and the analog OTA cell on the `ua` pins.

Parameters:
- N_REQ, 4, number of requesters; must be ≥ 2.
- SETTLE_W, 8, width of the `settle_cycles` configuration input.
- ID_W, $clog2(N_REQ), width of `ota_sel`, `rsp_id` and the round-robin pointer.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester level request.
- settle_cycles  in  SETTLE_W  settle time in clocks; sampled at grant.
- ota_out  in  1  raw OTA output; asynchronous to `clk`.
- ota_en  out  1  OTA enable.
- ota_sel  out  ID_W  input-pair mux select; equals the granted id.
- gnt  out  N_REQ  one-hot grant, held for the whole operation.
- busy  out  1  high in any state other than IDLE.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  ID_W  id of the completed request.
- rsp_bit  out  1  sampled comparator decision.

Behaviour:
- Reset, asynchronous, any state: all outputs 0, state IDLE, RR pointer 0, synchroniser flops 0.
  - Mid-operation reset drops `ota_en` and `gnt` immediately; no `rsp_valid` is issued for the aborted request.
- `ota_out` passes through a 2-flop synchroniser; `sync_q` is the second stage.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If any `req` bit is set: grant the lowest index ≥ pointer, wrapping modulo N_REQ.
  - Register `gnt`, `ota_sel`, `ota_en`=1, `busy`=1.
  - Load the counter with L = max(`settle_cycles`, 2); the minimum covers synchroniser latency.
  - Pointer ← (granted id + 1) mod N_REQ.
  - Go to SETTLE.
- SETTLE: decrement the counter each cycle; when it reaches 1, go to SAMPLE. SETTLE therefore lasts exactly L cycles.
- SAMPLE: capture `sync_q` into `rsp_bit`; go to DONE.
- DONE:
  - `rsp_valid`=1 and `rsp_id`=granted id for exactly one cycle.
  - `ota_en`, `gnt`, `busy` → 0.
  - Go to IDLE.
  - `rsp_bit` and `rsp_id` hold their values until the next DONE.
- Latency: request seen in IDLE at cycle T → `rsp_valid` in cycle T+L+2.
- Minimum spacing between back-to-back operations is L+3 cycles, because IDLE is always visited for one cycle.
- `req` is level-sensitive and is not a protocol violation if dropped. Dropping it after grant does not abort: the operation completes and the result is reported.
- `req` bits are ignored while `busy`=1.
- `settle_cycles` changes after grant have no effect on the current operation.
- `settle_cycles` values 0, 1 and 2 all give L=2. Maximum L is 2^SETTLE_W − 1; no wrap.
- Only one requester is granted at a time. `gnt` is one-hot or zero, never multi-hot.
- Fairness: a continuously requesting requester waits at most N_REQ−1 operations.

Optional Feature:
- Macro DOTA_SCHED_MAJORITY_EN.
- Defined: SAMPLE lasts 3 cycles, capturing `sync_q` on each. `rsp_bit` = majority of the 3 samples. Latency becomes T+L+4.
- Undefined: single sample, as above.

Decomposition:
- Package `dota_pkg`:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - MIN_SETTLE=2
  - SYNC_STAGES=2
  - MAJ_SAMPLES=3
- One sub-module, `dota_rr_arb`: combinational round-robin pick from (`req`, pointer) → one-hot grant plus encoded id. The pointer register stays in `dota_sched`.

Test Plan:
- Reset, then `req`=0001, `settle_cycles`=5, `ota_out`=1 steady → `gnt`=0001, `ota_en` high 7 cycles, `rsp_valid` at T+7, `rsp_id`=0, `rsp_bit`=1.
- `req`=1111 held continuously, `settle_cycles`=3 → grants in order 0,1,2,3,0; `rsp_id` sequence 0,1,2,3,0; `rsp_valid` every 6 cycles.
- `settle_cycles`=0 with `req`=0100 → L=2; `rsp_valid` at T+4, `rsp_id`=2.
- `req`=0010 dropped one cycle after grant → operation completes; `rsp_valid` with `rsp_id`=1.
- `rst` asserted during SETTLE → `ota_en`, `gnt`, `busy` 0 immediately; no `rsp_valid`; next grant starts from pointer 0.
- MAJORITY_EN build, `ota_out` toggling 1,0,1 across the SAMPLE window → `rsp_bit`=1; `rsp_valid` at T+L+4.
